// File: rtl/fc_2nd_mac_engine.sv
// rtl/fc_2nd_mac_engine.sv - FC2 compute sequencer: weight RAM fetch, 5-lane MAC, bias, rescale, saturate
module fc_2nd_mac_engine #(
    parameter int Bit_width = 16,
    parameter int IN_LEN    = 4,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter bit RELU      = 1'b0
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Weight_En,
    output logic [3:0]           Weight_Idx,
    input  logic [Bit_width-1:0] Bias_in,
    input  logic [Bit_width-1:0] W1_in,
    input  logic [Bit_width-1:0] W2_in,
    input  logic [Bit_width-1:0] W3_in,
    input  logic [Bit_width-1:0] W4_in,
    input  logic [Bit_width-1:0] W5_in,
    input  logic [Bit_width-1:0] X_in,
    input  logic                 X_valid,
    output logic                 X_ready,
    output logic [Bit_width-1:0] Y1,
    output logic [Bit_width-1:0] Y2,
    output logic [Bit_width-1:0] Y3,
    output logic [Bit_width-1:0] Y4,
    output logic [Bit_width-1:0] Y5,
    output logic                 Y_valid,
    input  logic                 Y_ready
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_MAC, S_BIAS, S_OUT} state_t;

    localparam int PW = 2 * Bit_width;
    localparam logic [3:0] L_LAST = 4'(IN_LEN - 1);
    localparam logic signed [ACC_W-1:0] L_MAX = {{(ACC_W-Bit_width+1){1'b0}}, {(Bit_width-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] L_MIN = {{(ACC_W-Bit_width+1){1'b1}}, {(Bit_width-1){1'b0}}};

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_wen;
    logic                    r_xrdy;
    logic                    r_yvalid;
    logic [3:0]              r_idx;
    logic signed [ACC_W-1:0] r_acc [5];
    logic [Bit_width-1:0]    r_y [5];

    logic [Bit_width-1:0]    w_w [5];
    logic signed [PW-1:0]    w_p [5];
    logic signed [ACC_W-1:0] w_prod [5];
    logic signed [ACC_W-1:0] w_sum [5];
    logic signed [ACC_W-1:0] w_shift [5];
    logic [Bit_width-1:0]    w_res [5];
    logic signed [ACC_W-1:0] w_bias;

    assign w_w[0] = W1_in;
    assign w_w[1] = W2_in;
    assign w_w[2] = W3_in;
    assign w_w[3] = W4_in;
    assign w_w[4] = W5_in;

    // Bias is aligned to the product scale (2*FRAC_BITS fractional bits) before the add.
    assign w_bias = {{(ACC_W-Bit_width){Bias_in[Bit_width-1]}}, Bias_in} <<< FRAC_BITS;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_p[k]     = $signed({{Bit_width{w_w[k][Bit_width-1]}}, w_w[k]})
                       * $signed({{Bit_width{X_in[Bit_width-1]}}, X_in});
            w_prod[k]  = {{(ACC_W-PW){w_p[k][PW-1]}}, w_p[k]};
            w_sum[k]   = r_acc[k] + w_bias;
            w_shift[k] = w_sum[k] >>> FRAC_BITS;
            if (w_shift[k] > L_MAX)
                w_res[k] = L_MAX[Bit_width-1:0];
            else if (w_shift[k] < L_MIN)
                w_res[k] = L_MIN[Bit_width-1:0];
            else
                w_res[k] = w_shift[k][Bit_width-1:0];
            if (RELU && w_res[k][Bit_width-1])
                w_res[k] = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_wen    <= 1'b0;
            r_xrdy   <= 1'b0;
            r_yvalid <= 1'b0;
            r_idx    <= '0;
            for (int k = 0; k < 5; k++) begin
                r_acc[k] <= '0;
                r_y[k]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        for (int k = 0; k < 5; k++) r_acc[k] <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_wen   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_xrdy  <= 1'b1;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (X_valid) begin
                        for (int k = 0; k < 5; k++) r_acc[k] <= r_acc[k] + w_prod[k];
                        r_xrdy <= 1'b0;
                        if (r_idx == L_LAST) begin
                            r_state <= S_BIAS;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_BIAS: begin
                    // Results are formed from acc+bias in the same edge that enters OUT.
                    for (int k = 0; k < 5; k++) begin
                        r_acc[k] <= w_sum[k];
                        r_y[k]   <= w_res[k];
                    end
                    r_yvalid <= 1'b1;
                    r_wen    <= 1'b0;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (Y_ready) begin
                        for (int k = 0; k < 5; k++) r_y[k] <= '0;
                        r_yvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy       = r_busy;
    assign Weight_En  = r_wen;
    assign Weight_Idx = r_idx;
    assign X_ready    = r_xrdy;
    assign Y_valid    = r_yvalid;
    assign Y1         = r_y[0];
    assign Y2         = r_y[1];
    assign Y3         = r_y[2];
    assign Y4         = r_y[3];
    assign Y5         = r_y[4];
endmodule

// File: tb/tb_fc_2nd_mac_engine.sv
// tb/tb_fc_2nd_mac_engine.sv - randomized model-checked bench for fc_2nd_mac_engine
module tb_fc_2nd_mac_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic [2:0]  yready;
    logic [15:0] x_in;
    logic        x_valid;
    logic [2:0]  busy, wen, xrdy, yv;
    logic [3:0]  widx [3];
    logic [15:0] bias_o [3];
    logic [15:0] w_o [3][5];
    logic [15:0] y_o [3][5];

    logic signed [15:0] tb_w [16][5];
    logic signed [15:0] tb_b [16];
    logic signed [15:0] xs [16];
    logic signed [15:0] exp_y [5];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: IN_LEN=4, instance 1: IN_LEN=4 with RELU, instance 2: IN_LEN=1.
    for (genvar i = 0; i < 3; i++) begin : g_dut
        fc_2nd_mac_engine #(.IN_LEN(i == 2 ? 1 : 4), .RELU(i == 1)) u_dut (
            .CLK(clk), .Reset(reset), .Start(start[i]), .Busy(busy[i]),
            .Weight_En(wen[i]), .Weight_Idx(widx[i]), .Bias_in(bias_o[i]),
            .W1_in(w_o[i][0]), .W2_in(w_o[i][1]), .W3_in(w_o[i][2]),
            .W4_in(w_o[i][3]), .W5_in(w_o[i][4]),
            .X_in(x_in), .X_valid(x_valid), .X_ready(xrdy[i]),
            .Y1(y_o[i][0]), .Y2(y_o[i][1]), .Y3(y_o[i][2]), .Y4(y_o[i][3]), .Y5(y_o[i][4]),
            .Y_valid(yv[i]), .Y_ready(yready[i])
        );
    end

    // Weight RAM model: updates on negedge, zero while disabled.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wen[i]) begin
                bias_o[i] <= tb_b[widx[i]];
                for (int k = 0; k < 5; k++) w_o[i][k] <= tb_w[widx[i]][k];
            end else begin
                bias_o[i] <= '0;
                for (int k = 0; k < 5; k++) w_o[i][k] <= '0;
            end
        end
    end

    function automatic void compute_expected(input int n, input bit relu);
        longint acc, v;
        for (int k = 0; k < 5; k++) begin
            acc = longint'(tb_b[n-1]) * 256;
            for (int j = 0; j < n; j++) acc += longint'(tb_w[j][k]) * longint'(xs[j]);
            v = acc >>> 8;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            if (relu && v < 0) v = 0;
            exp_y[k] = 16'(v);
        end
    endfunction

    task automatic set_nominal();
        int w1 [4] = '{-316, 267, -359, -297};
        int w2 [4] = '{267, -380, 217, 0};
        int w3 [4] = '{259, -364, 195, 0};
        int w4 [4] = '{176, 190, 266, 0};
        int w5 [4] = '{-372, -396, -351, 0};
        for (int j = 0; j < 4; j++) begin
            tb_w[j][0] = 16'(w1[j]); tb_w[j][1] = 16'(w2[j]); tb_w[j][2] = 16'(w3[j]);
            tb_w[j][3] = 16'(w4[j]); tb_w[j][4] = 16'(w5[j]);
            tb_b[j] = 16'sd29;
            xs[j] = 16'sd256;
        end
    endtask

    task automatic run(input int sel, input int n, input int stall_at, input int stall_len,
                       input int yhold, input bit spurious, input int lat_exp);
        int k = 0, stall = 0, held = 0, cyc = 0;
        bit drv_x = 0, hs = 0, lat_seen = 0, done = 0;
        compute_expected(n, sel == 1);
        start[sel] = 1'b1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            if (drv_x) k++;
            drv_x = 0;
            if (hs) begin
                n_vec++;
                if (yv[sel] !== 1'b0 || busy[sel] !== 1'b0 || wen[sel] !== 1'b0) begin
                    n_err++;
                    $display("FAIL post_handshake inst%0d: yv=%b busy=%b wen=%b, want 0 0 0", sel, yv[sel], busy[sel], wen[sel]);
                end
                for (int q = 0; q < 5; q++) begin
                    n_vec++;
                    if (y_o[sel][q] !== 16'd0) begin
                        n_err++;
                        $display("FAIL y_zero inst%0d Y%0d: got %0d, want 0", sel, q+1, $signed(y_o[sel][q]));
                    end
                end
                done = 1;
            end else begin
                start[sel] = 1'b0;
                x_valid = 1'b0;
                if (yv[sel]) begin
                    if (!lat_seen) begin
                        lat_seen = 1;
                        if (lat_exp > 0) begin
                            n_vec++;
                            if (cyc !== lat_exp) begin
                                n_err++;
                                $display("FAIL latency inst%0d: got %0d, want %0d", sel, cyc, lat_exp);
                            end
                        end
                    end
                    for (int q = 0; q < 5; q++) begin
                        n_vec++;
                        if ($signed(y_o[sel][q]) !== exp_y[q]) begin
                            n_err++;
                            $display("FAIL result inst%0d Y%0d: got %0d, want %0d", sel, q+1, $signed(y_o[sel][q]), exp_y[q]);
                        end
                    end
                    if (held >= yhold) begin
                        yready[sel] = 1'b1;
                        hs = 1;
                        if (spurious) start[sel] = 1'b1;
                    end else begin
                        held++;
                        yready[sel] = 1'b0;
                    end
                end else begin
                    yready[sel] = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (xrdy[sel]) begin
                        n_vec++;
                        if (widx[sel] !== 4'(k)) begin
                            n_err++;
                            $display("FAIL weight_idx inst%0d: got %0d, want %0d", sel, widx[sel], k);
                        end
                        if (k == stall_at && stall < stall_len) begin
                            stall++;
                        end else begin
                            x_valid = 1'b1;
                            x_in = xs[k];
                            drv_x = 1;
                        end
                    end else if (spurious) begin
                        x_valid = 1'($urandom_range(0, 1));
                        x_in = 16'($urandom);
                    end
                    if (spurious && busy[sel]) start[sel] = 1'($urandom_range(0, 1));
                end
            end
        end
        start = '0; x_valid = 1'b0; yready = '0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout inst%0d: no result handshake in %0d cycles", sel, cyc);
        end else begin
            @(posedge clk); #1;
            n_vec++;
            if (busy[sel] !== 1'b0) begin
                n_err++;
                $display("FAIL no_restart inst%0d: busy=%b, want 0", sel, busy[sel]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({busy[i], wen[i], xrdy[i], yv[i], widx[i]} !== 8'd0) begin
                n_err++;
                $display("FAIL reset_ctrl inst%0d: got %b, want 0", i, {busy[i], wen[i], xrdy[i], yv[i], widx[i]});
            end
            for (int q = 0; q < 5; q++) begin
                n_vec++;
                if (y_o[i][q] !== 16'd0) begin
                    n_err++;
                    $display("FAIL reset_y inst%0d Y%0d: got %0d, want 0", i, q+1, y_o[i][q]);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        set_nominal();
        run(0, 4, -1, 0, 0, 0, 10);
    endtask

    task automatic test_stalls();
        set_nominal();
        run(0, 4, 2, 3, 5, 0, 0);
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 5; k++) tb_w[j][k] = 16'sh7FFF;
            xs[j] = 16'sh7FFF;
            tb_b[j] = '0;
        end
        run(0, 4, -1, 0, 0, 0, 10);
        run(1, 4, -1, 0, 0, 0, 10);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 5; k++) tb_w[j][k] = 16'sh8000;
        run(0, 4, -1, 0, 0, 0, 10);
        run(1, 4, -1, 0, 0, 0, 10);
    endtask

    task automatic test_reset_mid_run();
        bit hit = 0;
        set_nominal();
        start[0] = 1'b1; x_valid = 1'b1; x_in = 16'd256;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
            if (xrdy[0] && widx[0] == 4'd1) hit = 1;
        end
        x_valid = 1'b0;
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL reach_mac_idx1: not reached, want MAC at idx 1");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++;
        if ({busy[0], wen[0], xrdy[0], yv[0]} !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset_ctrl: got %b, want 0000", {busy[0], wen[0], xrdy[0], yv[0]});
        end
        for (int q = 0; q < 5; q++) begin
            n_vec++;
            if (y_o[0][q] !== 16'd0) begin
                n_err++;
                $display("FAIL mid_reset_y Y%0d: got %0d, want 0", q+1, y_o[0][q]);
            end
        end
        run(0, 4, -1, 0, 0, 0, 10);
    endtask

    task automatic test_ignored();
        set_nominal();
        for (int c = 0; c < 4; c++) begin
            x_valid = 1'b1; x_in = 16'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if (busy[0] !== 1'b0 || xrdy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL idle_xvalid: busy=%b xrdy=%b, want 0 0", busy[0], xrdy[0]);
            end
        end
        x_valid = 1'b0;
        run(0, 4, 1, 2, 2, 1, 0);
    endtask

    task automatic test_edge_length();
        for (int k = 0; k < 5; k++) tb_w[0][k] = 16'((k + 1) * 256);
        xs[0] = 16'sd512;
        tb_b[0] = -16'sd256;
        run(2, 1, -1, 0, 0, 0, 4);
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int sel, n;
            sel = $urandom_range(0, 2);
            n = (sel == 2) ? 1 : 4;
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < 5; k++) tb_w[j][k] = 16'($urandom);
                xs[j] = 16'($urandom);
                tb_b[j] = 16'($urandom);
            end
            run(sel, n, $urandom_range(0, n - 1), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = '0; yready = '0; x_valid = 1'b0; x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_stalls();
        test_saturation();
        test_reset_mid_run();
        test_ignored();
        test_edge_length();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
